// File: rtl/packet_fifo.sv
// Packet FIFO between a traffic source and a mesh input port.
// First-word-fall-through, registered occupancy, no write bypass.
package noc_pkg;
  typedef struct packed {
    logic [7:0]  x_dest;
    logic [7:0]  y_dest;
    logic [15:0] payload;
  } packet_t;
endpackage

module packet_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PKT_W = $bits(packet_t)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [PKT_W-1:0] i_data,
  input  logic             i_data_val,
  input  logic             i_en,
  output logic [PKT_W-1:0] o_data,
  output logic             o_data_val,
  output logic             o_en
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we, re;

  assign o_data     = mem_q[rd_ptr_q];
  assign o_data_val = (cnt_q != '0);
  assign o_en       = (cnt_q != CW'(DEPTH));

  // full blocks writes even when a pop happens in the same cycle
  assign we = ce & i_data_val & o_en;
  assign re = ce & i_en & o_data_val;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (re) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    if (we) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    unique case (1'b1)
      we && !re: cnt_d = cnt_q + CW'(1);
      re && !we: cnt_d = cnt_q - CW'(1);
      default:   cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we) begin
        mem_q[wr_ptr_q] <= i_data;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_packet_fifo.sv
// Directed bench for packet_fifo, DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_packet_fifo;
  import noc_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic [31:0] i_data;
  logic        i_data_val;
  logic        i_en;
  logic [31:0] o_data;
  logic        o_data_val;
  logic        o_en;

  int vec_n;
  int err_n;

  packet_fifo #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .i_data     (i_data),
    .i_data_val (i_data_val),
    .i_en       (i_en),
    .o_data     (o_data),
    .o_data_val (o_data_val),
    .o_en       (o_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int x);
    packet_t p;
    p.x_dest  = 8'(x);
    p.y_dest  = 8'(x ^ 8'h5a);
    p.payload = 16'(16'hc300 + x * 7);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x);
    i_data     = mk(x);
    i_data_val = 1'b1;
    tick();
    i_data_val = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input int x);
    chk({tag, "_val"}, 32'(o_data_val), 32'd1);
    chk({tag, "_data"}, o_data, mk(x));
    i_en = 1'b1;
    tick();
    i_en = 1'b0;
  endtask

  initial begin
    vec_n      = 0;
    err_n      = 0;
    reset_n    = 1'b0;
    ce         = 1'b1;
    i_data     = '0;
    i_data_val = 1'b0;
    i_en       = 1'b0;
    #12;
    chk("rst_val", 32'(o_data_val), 32'd0);
    chk("rst_en", 32'(o_en), 32'd1);
    chk("rst_data", o_data, 32'd0);
    reset_n = 1'b1;
    tick();

    // reset mid-run with 3 entries stored
    push(1);
    push(2);
    push(3);
    chk("pre_rst_head", o_data, mk(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_val", 32'(o_data_val), 32'd0);
    chk("midrst_en", 32'(o_en), 32'd1);
    chk("midrst_data", o_data, 32'd0);
    #3;
    reset_n = 1'b1;
    tick();
    i_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_val", 32'(o_data_val), 32'd0);
      chk("idle_en", 32'(o_en), 32'd1);
    end
    i_en = 1'b0;

    // fill to full, overflow dropped, drain in order
    for (int i = 0; i < 4; i++) begin
      chk("fill_en", 32'(o_en), 32'd1);
      push(i);
    end
    chk("full_en", 32'(o_en), 32'd0);
    push(9);
    chk("ovf_en", 32'(o_en), 32'd0);
    for (int i = 0; i < 4; i++) pop_chk("drain", i);
    chk("drain_empty", 32'(o_data_val), 32'd0);

    // fall-through latency
    chk("ft_pre_val", 32'(o_data_val), 32'd0);
    push(5);
    chk("ft_val", 32'(o_data_val), 32'd1);
    chk("ft_data", o_data, mk(5));
    i_en = 1'b1;
    tick();
    i_en = 1'b0;
    chk("ft_pop_val", 32'(o_data_val), 32'd0);

    // concurrent read/write at count 2, pointers wrap
    push(100);
    push(101);
    i_en = 1'b1;
    i_data_val = 1'b1;
    for (int i = 0; i < 11; i++) begin
      int exp_head;
      exp_head = (i == 0) ? 100 : (i == 1) ? 101 : 8 + i;
      chk("cc_head", o_data, mk(exp_head));
      i_data = mk(10 + i);
      tick();
      chk("cc_val", 32'(o_data_val), 32'd1);
      chk("cc_en", 32'(o_en), 32'd1);
    end
    i_en = 1'b0;
    i_data_val = 1'b0;
    pop_chk("cc_tail", 19);
    pop_chk("cc_tail", 20);
    chk("cc_empty", 32'(o_data_val), 32'd0);

    // full with simultaneous read and write
    for (int i = 30; i < 34; i++) push(i);
    chk("fw_full", 32'(o_en), 32'd0);
    i_en = 1'b1;
    i_data_val = 1'b1;
    i_data = mk(40);
    tick();
    i_en = 1'b0;
    i_data_val = 1'b0;
    chk("fw_en", 32'(o_en), 32'd1);
    pop_chk("fw_drain", 31);
    pop_chk("fw_drain", 32);
    pop_chk("fw_drain", 33);
    chk("fw_empty", 32'(o_data_val), 32'd0);

    // clock-enable gating
    push(50);
    push(51);
    ce = 1'b0;
    i_data_val = 1'b1;
    i_data = mk(52);
    i_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ce_head", o_data, mk(50));
      chk("ce_val", 32'(o_data_val), 32'd1);
      chk("ce_en", 32'(o_en), 32'd1);
    end
    i_data_val = 1'b0;
    i_en = 1'b0;
    ce = 1'b1;
    pop_chk("ce_resume", 50);
    pop_chk("ce_resume", 51);
    chk("ce_empty", 32'(o_data_val), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
